gift_iter_dec: RTL

Iterative GIFT-128 decryption core: the decrypting counterpart of the pipelined GIFT-128 encryptor. It accepts a 128-bit ciphertext and 128-bit master key and runs the key schedule forward to the round-40 key. It then applies 40 inverse rounds, one per clock, and presents the plaintext with a one-cycle valid strobe. The core is area-oriented, sits on the receive side of the cipher datapath, and uses the same load/valid handshake as the encryptor.

---
 rtl/gift_iter_dec.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/gift_iter_dec.sv
// gift_iter_dec: area-oriented iterative GIFT-128 decryptor.
// A block is loaded, the key schedule is run forward to K40, and 40 inverse
// rounds are applied, one per clock. The key register returns to the master
// key at the end of every block, so one key load serves many blocks.
`default_nettype none

module gift_iter_dec (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outValidData,
  output logic         outBusy
);

  localparam int unsigned BLK_W       = 128;
  localparam int unsigned NIB_N       = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned RC_W        = 6;
  localparam int unsigned ROUNDS      = 40;
  localparam int unsigned KEYFWD_LAST = ROUNDS - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYFWD,
    ST_ROUND
  } state_e;

  state_e             fsm_q;
  logic [BLK_W-1:0]   state_q;
  logic [BLK_W-1:0]   key_q;
  logic [BLK_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               out_busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [RC_W-1:0]    rc_c;
  logic [BLK_W-1:0]   rk_mask_c;
  logic [BLK_W-1:0]   ark_c;
  logic [BLK_W-1:0]   iperm_c;
  logic [BLK_W-1:0]   isub_c;
  logic [BLK_W-1:0]   key_fwd_c;
  logic [BLK_W-1:0]   key_inv_c;

  // Forward LFSR round-constant sequence; entry idx holds C_(idx+1).
  function automatic logic [RC_W-1:0] rc_rom(input logic [CNT_W-1:0] idx);
    case (idx)
      6'd0:  return 6'h01;
      6'd1:  return 6'h03;
      6'd2:  return 6'h07;
      6'd3:  return 6'h0F;
      6'd4:  return 6'h1F;
      6'd5:  return 6'h3E;
      6'd6:  return 6'h3D;
      6'd7:  return 6'h3B;
      6'd8:  return 6'h37;
      6'd9:  return 6'h2F;
      6'd10: return 6'h1E;
      6'd11: return 6'h3C;
      6'd12: return 6'h39;
      6'd13: return 6'h33;
      6'd14: return 6'h27;
      6'd15: return 6'h0E;
      6'd16: return 6'h1D;
      6'd17: return 6'h3A;
      6'd18: return 6'h35;
      6'd19: return 6'h2B;
      6'd20: return 6'h16;
      6'd21: return 6'h2C;
      6'd22: return 6'h18;
      6'd23: return 6'h30;
      6'd24: return 6'h21;
      6'd25: return 6'h02;
      6'd26: return 6'h05;
      6'd27: return 6'h0B;
      6'd28: return 6'h17;
      6'd29: return 6'h2E;
      6'd30: return 6'h1C;
      6'd31: return 6'h38;
      6'd32: return 6'h31;
      6'd33: return 6'h23;
      6'd34: return 6'h06;
      6'd35: return 6'h0D;
      6'd36: return 6'h1B;
      6'd37: return 6'h36;
      6'd38: return 6'h2D;
      6'd39: return 6'h1A;
      default: return 6'h00;
    endcase
  endfunction

  // Inverse of the GIFT S-box 1A4C6F392DB7508E.
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hD;
      4'h1: return 4'h0;
      4'h2: return 4'h8;
      4'h3: return 4'h6;
      4'h4: return 4'h2;
      4'h5: return 4'hC;
      4'h6: return 4'h4;
      4'h7: return 4'hB;
      4'h8: return 4'hE;
      4'h9: return 4'h7;
      4'hA: return 4'h1;
      4'hB: return 4'hA;
      4'hC: return 4'h3;
      4'hD: return 4'h9;
      4'hE: return 4'hF;
      default: return 4'h5;
    endcase
  endfunction

  // Round constant for the current round index r (counter holds r in ROUND).
  always_comb begin
    rc_c = rc_rom(cnt_q - 6'd1);
  end

  // Round-key / constant mask: bit 4i+2 <- U[i], bit 4i+1 <- V[i],
  // bit 4i+3 carries c_i for nibbles 0..5 and the fixed 1 at bit 127.
  for (genvar g = 0; g < NIB_N; g++) begin : g_rk
    logic rc_bit_c;
    if (g < RC_W) begin : g_rc
      assign rc_bit_c = rc_c[g];
    end else if (g == NIB_N - 1) begin : g_top
      assign rc_bit_c = 1'b1;
    end else begin : g_none
      assign rc_bit_c = 1'b0;
    end
    assign rk_mask_c[4*g +: 4] = {rc_bit_c, key_q[64+g], key_q[g], 1'b0};
  end

  assign ark_c = state_q ^ rk_mask_c;

  // Inverse PermBits: the bit that forward permutation sent to P(b) returns to b.
  for (genvar b = 0; b < BLK_W; b++) begin : g_iperm
    localparam int unsigned SRC = 4 * (b / 16)
                                + 32 * ((3 * ((b % 16) / 4) + (b % 4)) % 4)
                                + (b % 4);
    assign iperm_c[b] = ark_c[SRC];
  end

  // Inverse SubCells across all 32 nibbles.
  for (genvar g = 0; g < NIB_N; g++) begin : g_isub
    assign isub_c[4*g +: 4] = inv_sbox(iperm_c[4*g +: 4]);
  end

  // Forward key update: (k1>>>2)||(k0>>>12)||k7..k2.
  assign key_fwd_c = {key_q[17:16], key_q[31:18],
                      key_q[11:0],  key_q[15:12],
                      key_q[127:32]};

  // Inverse key update: k5..k0||(k7<<<2)||(k6<<<12).
  assign key_inv_c = {key_q[95:0],
                      key_q[125:112], key_q[127:126],
                      key_q[99:96],   key_q[111:100]};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_busy_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (inKeyWr) begin
            key_q <= inKeyData;
          end
          if (inDataWr) begin
            state_q    <= inDataData;
            cnt_q      <= '0;
            out_busy_q <= 1'b1;
            fsm_q      <= ST_KEYFWD;
          end
        end
        ST_KEYFWD: begin
          key_q <= key_fwd_c;
          if (cnt_q == CNT_W'(KEYFWD_LAST)) begin
            cnt_q <= CNT_W'(ROUNDS);
            fsm_q <= ST_ROUND;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_ROUND: begin
          if (cnt_q != '0) begin
            state_q <= isub_c;
            cnt_q   <= cnt_q - 6'd1;
            // Round 1 leaves the key at K1 so the master key is retained.
            if (cnt_q != 6'd1) begin
              key_q <= key_inv_c;
            end
          end else begin
            out_data_q  <= state_q;
            out_valid_q <= 1'b1;
            out_busy_q  <= 1'b0;
            fsm_q       <= ST_IDLE;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign outData      = out_data_q;
  assign outValidData = out_valid_q;
  assign outBusy      = out_busy_q;

endmodule

`default_nettype wire
